// File: rtl/ram_1r1w_sync_core.sv
// Synchronous 1R1W word RAM with registered read data and read-first collisions.
// Define RAM_1R1W_SYNC_BYPASS_EN to make same-address collisions write-first.
module ram_1r1w_sync_core #(
   parameter  int width_p   = 32,
   parameter  int depth_p   = 1024,
   localparam int addr_w_lp = $clog2(depth_p)
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 wr_valid_i,
   input  logic [width_p-1:0]   wr_data_i,
   input  logic [addr_w_lp-1:0] wr_addr_i,
   input  logic                 rd_valid_i,
   input  logic [addr_w_lp-1:0] rd_addr_i,
   output logic [width_p-1:0]   rd_data_o
);

   // One extra bit so depth_p == 2**addr_w_lp is representable in the range compare.
   localparam logic [addr_w_lp:0] depth_lp = (addr_w_lp+1)'(depth_p);

   // Left without reset or initial clearing so an external preload survives.
   logic [width_p-1:0] mem [0:depth_p-1];

   logic               wr_in_range;
   logic               rd_in_range;
   logic               wr_en;
   logic [width_p-1:0] rd_data_d;
   logic [width_p-1:0] rd_data_q;

   always_comb begin
      wr_in_range = ({1'b0, wr_addr_i} < depth_lp);
      rd_in_range = ({1'b0, rd_addr_i} < depth_lp);
      wr_en       = wr_valid_i & wr_in_range & ~reset_i;
      rd_data_d   = rd_data_q;
      if (rd_valid_i) begin
         if (!rd_in_range) begin
            rd_data_d = '0;
`ifdef RAM_1R1W_SYNC_BYPASS_EN
         end else if (wr_en && (wr_addr_i == rd_addr_i)) begin
            rd_data_d = wr_data_i;
`endif
         end else begin
            rd_data_d = mem[rd_addr_i];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: tb/tb_ram_1r1w_sync_core.sv
// Bench for ram_1r1w_sync_core: directed vector table on a 1024-word instance,
// randomized traffic against an array model on a 1000-word instance.
module tb_ram_1r1w_sync_core;

   logic clk;
   logic reset;

   logic        wv, rv;
   logic [9:0]  wa, ra;
   logic [31:0] wd, rd_data;

   logic        r_wv, r_rv;
   logic [9:0]  r_wa, r_ra;
   logic [31:0] r_wd, r_rd_data;

   int passed = 0;
   int total  = 0;

   ram_1r1w_sync_core #(.width_p(32), .depth_p(1024)) dut (
      .clk_i(clk), .reset_i(reset),
      .wr_valid_i(wv), .wr_data_i(wd), .wr_addr_i(wa),
      .rd_valid_i(rv), .rd_addr_i(ra), .rd_data_o(rd_data)
   );

   ram_1r1w_sync_core #(.width_p(32), .depth_p(1000)) dut_r (
      .clk_i(clk), .reset_i(reset),
      .wr_valid_i(r_wv), .wr_data_i(r_wd), .wr_addr_i(r_wa),
      .rd_valid_i(r_rv), .rd_addr_i(r_ra), .rd_data_o(r_rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        wv;
      logic [9:0]  wa;
      logic [31:0] wd;
      logic        rv;
      logic [9:0]  ra;
      logic [31:0] exp;
   } vec_t;

`ifdef RAM_1R1W_SYNC_BYPASS_EN
   localparam logic [31:0] COLL_EXP = 32'h2222_2222;
   localparam bit          BYPASS   = 1'b1;
`else
   localparam logic [31:0] COLL_EXP = 32'h1111_1111;
   localparam bit          BYPASS   = 1'b0;
`endif

   vec_t vecs [18];
   logic [31:0] model [1000];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] exp_r;
      logic [31:0] prev_r;

      // reset with colliding traffic, then preload checks
      vecs[0]  = '{1'b1, 1'b1, 10'd5,    32'hAAAA_AAAA, 1'b1, 10'd5,    32'h0};
      vecs[1]  = '{1'b1, 1'b1, 10'd5,    32'hAAAA_AAAA, 1'b1, 10'd5,    32'h0};
      vecs[2]  = '{1'b0, 1'b0, 10'd0,    32'h0,         1'b0, 10'd0,    32'h0};
      vecs[3]  = '{1'b0, 1'b0, 10'd0,    32'h0,         1'b1, 10'd5,    32'h5555_5555};
      vecs[4]  = '{1'b0, 1'b0, 10'd0,    32'h0,         1'b1, 10'd0,    32'hCAFE_F00D};
      // write / back-to-back readback
      vecs[5]  = '{1'b0, 1'b1, 10'd3,    32'hDEAD_BEEF, 1'b0, 10'd0,    32'hCAFE_F00D};
      vecs[6]  = '{1'b0, 1'b1, 10'd1023, 32'h1234_5678, 1'b0, 10'd0,    32'hCAFE_F00D};
      vecs[7]  = '{1'b0, 1'b0, 10'd0,    32'h0,         1'b1, 10'd3,    32'hDEAD_BEEF};
      vecs[8]  = '{1'b0, 1'b0, 10'd0,    32'h0,         1'b1, 10'd1023, 32'h1234_5678};
      // hold across a write to the same word
      vecs[9]  = '{1'b0, 1'b0, 10'd0,    32'h0,         1'b1, 10'd3,    32'hDEAD_BEEF};
      vecs[10] = '{1'b0, 1'b1, 10'd3,    32'h0,         1'b0, 10'd3,    32'hDEAD_BEEF};
      vecs[11] = '{1'b0, 1'b0, 10'd0,    32'h0,         1'b0, 10'd0,    32'hDEAD_BEEF};
      vecs[12] = '{1'b0, 1'b0, 10'd0,    32'h0,         1'b1, 10'd3,    32'h0};
      // collision and independent read/write
      vecs[13] = '{1'b0, 1'b1, 10'd7,    32'h1111_1111, 1'b0, 10'd0,    32'h0};
      vecs[14] = '{1'b0, 1'b1, 10'd7,    32'h2222_2222, 1'b1, 10'd7,    COLL_EXP};
      vecs[15] = '{1'b0, 1'b0, 10'd0,    32'h0,         1'b1, 10'd7,    32'h2222_2222};
      vecs[16] = '{1'b0, 1'b1, 10'd9,    32'h3333_3333, 1'b1, 10'd7,    32'h2222_2222};
      vecs[17] = '{1'b0, 1'b0, 10'd0,    32'h0,         1'b1, 10'd9,    32'h3333_3333};

      dut.mem[0] = 32'hCAFE_F00D;
      dut.mem[5] = 32'h5555_5555;

      reset = 1'b0;
      wv = 1'b0; wa = '0; wd = '0; rv = 1'b0; ra = '0;
      r_wv = 1'b0; r_wa = '0; r_wd = '0; r_rv = 1'b0; r_ra = '0;

      for (int i = 0; i < 18; i++) begin
         reset = vecs[i].rst;
         wv = vecs[i].wv; wa = vecs[i].wa; wd = vecs[i].wd;
         rv = vecs[i].rv; ra = vecs[i].ra;
         tick();
         check($sformatf("vec%0d", i), rd_data, vecs[i].exp);
      end

      // Mid-run reset clears read data and suppresses the write in that cycle.
      reset = 1'b1; wv = 1'b1; wa = 10'd9; wd = 32'hFFFF_FFFF; rv = 1'b1; ra = 10'd9;
      tick();
      check("midreset_zero", rd_data, 32'h0);
      reset = 1'b0; wv = 1'b0;
      tick();
      check("midreset_mem_kept", rd_data, 32'h3333_3333);
      rv = 1'b0;

      // Fill the 1000-word instance so every in-range word has a known value.
      for (int a = 0; a < 1000; a++) begin
         r_wv = 1'b1; r_wa = 10'(a); r_wd = $urandom;
         model[a] = r_wd;
         tick();
      end

      prev_r = 32'h0;
      for (int c = 0; c < 1000; c++) begin
         r_wv = 1'($urandom_range(0, 1));
         r_rv = 1'($urandom_range(0, 1));
         r_wa = 10'($urandom_range(0, 1023));
         r_ra = (c % 4 == 0) ? r_wa : 10'($urandom_range(0, 1023));
         r_wd = $urandom;
         if (!r_rv) exp_r = prev_r;
         else if (int'(r_ra) >= 1000) exp_r = 32'h0;
         else if (BYPASS && r_wv && r_wa == r_ra) exp_r = r_wd;
         else exp_r = model[r_ra];
         if (r_wv && int'(r_wa) < 1000) model[r_wa] = r_wd;
         tick();
         check($sformatf("rand%0d ra=%0d", c, r_ra), r_rd_data, exp_r);
         prev_r = exp_r;
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
